// File: rtl/bnn_conv_stream.sv
// Streaming binary convolution engine.
// Latches an image and kernel bank, then emits LANES popcounts per beat.
module bnn_conv_stream #(
  parameter  int IMG_W = 28,
  parameter  int IMG_H = 28,
  parameter  int K     = 5,
  parameter  int N_KER = 90,
  parameter  int LANES = 10,
  parameter  int bW    = 8,
  localparam int OUT_W = IMG_W - K + 1,
  localparam int OUT_H = IMG_H - K + 1,
  localparam int NG    = N_KER / LANES,
  localparam int GW    = (NG > 1) ? $clog2(NG) : 1,
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_xnor_mode,
  input  logic [0:IMG_H*IMG_W-1]   i_image,
  input  logic [0:N_KER*K*K-1]     i_kernels,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [0:LANES*bW-1]      o_data,
  output logic [GW-1:0]            o_grp,
  output logic [RW-1:0]            o_row,
  output logic [CW-1:0]            o_col
);

  localparam int KK   = K * K;
  localparam int PW   = $clog2(KK + 1);
  localparam int IW   = $clog2(IMG_H * IMG_W);
  localparam int KW   = $clog2(N_KER * KK);
  localparam int MAXV = (1 << bW) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [0:IMG_H*IMG_W-1] img_lat;
  logic [0:N_KER*KK-1]    ker_lat;
  logic                   mode_lat;
  logic [GW-1:0]          grp;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col;
  logic                   have;

  logic [0:KK-1]          win;
  logic [0:LANES*bW-1]    lanes;

  logic col_last;
  logic row_last;
  logic grp_last;
  logic load;

  // Gather the KxK window anchored at the current row/col.
  for (genvar r = 0; r < K; r++) begin : g_wr
    for (genvar c = 0; c < K; c++) begin : g_wc
      logic [IW-1:0] pix;
      assign pix = IW'((int'(row) + r) * IMG_W + int'(col) + c);
      assign win[r*K+c] = img_lat[pix];
    end
  end

  // One popcount per lane, optional XNOR flip, then saturate to bW.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [KW-1:0] base;
    logic [0:KK-1] kb;
    logic [PW-1:0] pc;
    logic [PW-1:0] val;
    assign base = KW'((int'(grp) * LANES + l) * KK);
    assign kb   = ker_lat[base +: KK];
    assign pc   = PW'($countones(win ^ kb));
    assign val  = mode_lat ? PW'(KK) - pc : pc;
    assign lanes[l*bW +: bW] =
      (int'(val) > MAXV) ? bW'(MAXV) : bW'(val);
  end

  assign col_last = (col == CW'(OUT_W - 1));
  assign row_last = (row == RW'(OUT_H - 1));
  assign grp_last = (grp == GW'(NG - 1));
  assign load     = have && (!o_valid || i_ready);

  // Control FSM, position counters and the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      img_lat  <= '0;
      ker_lat  <= '0;
      mode_lat <= 1'b0;
      grp      <= '0;
      row      <= '0;
      col      <= '0;
      have     <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_grp    <= '0;
      o_row    <= '0;
      o_col    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            img_lat  <= i_image;
            ker_lat  <= i_kernels;
            mode_lat <= i_xnor_mode;
            grp      <= '0;
            row      <= '0;
            col      <= '0;
            have     <= 1'b1;
            o_busy   <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (load) begin
            o_valid <= 1'b1;
            o_data  <= lanes;
            o_grp   <= grp;
            o_row   <= row;
            o_col   <= col;
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row <= '0;
                if (grp_last) have <= 1'b0;
                else grp <= grp + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end else if (!have && o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_conv_stream.sv
// Bench for bnn_conv_stream: directed and random frames
// checked against a per-pixel reference model.
module tb_bnn_conv_stream;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int N_KER = 90;
  localparam int LANES = 10;
  localparam int BW    = 8;
  localparam int BW2   = 4;
  localparam int KK    = K * K;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int NG    = N_KER / LANES;
  localparam int TOTAL = NG * OUT_H * OUT_W;
  localparam int GW    = $clog2(NG);
  localparam int RW    = $clog2(OUT_H);
  localparam int CW    = $clog2(OUT_W);

  logic clk;
  logic rst;
  logic i_start;
  logic i_xnor_mode;
  logic [0:IMG_H*IMG_W-1] i_image;
  logic [0:N_KER*KK-1]    i_kernels;
  logic i_ready;

  logic busy, done, valid;
  logic [0:LANES*BW-1] data;
  logic [GW-1:0] grp;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic busy2, done2, valid2;
  logic [0:LANES*BW2-1] data2;
  logic [GW-1:0] grp2;
  logic [RW-1:0] row2;
  logic [CW-1:0] col2;

  bnn_conv_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K),
    .N_KER(N_KER), .LANES(LANES), .bW(BW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_xnor_mode(i_xnor_mode), .i_image(i_image),
    .i_kernels(i_kernels), .o_busy(busy), .o_done(done),
    .o_valid(valid), .i_ready(i_ready), .o_data(data),
    .o_grp(grp), .o_row(row), .o_col(col)
  );

  bnn_conv_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K),
    .N_KER(N_KER), .LANES(LANES), .bW(BW2)
  ) dut_sat (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_xnor_mode(i_xnor_mode), .i_image(i_image),
    .i_kernels(i_kernels), .o_busy(busy2), .o_done(done2),
    .o_valid(valid2), .i_ready(i_ready), .o_data(data2),
    .o_grp(grp2), .o_row(row2), .o_col(col2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit m_img [IMG_H][IMG_W];
  bit m_ker [N_KER][KK];
  bit m_mode;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected packed beats for both widths at one position.
  task automatic ref_beat(input int g, input int r, input int c,
                          output logic [127:0] e8,
                          output logic [127:0] e4);
    e8 = '0;
    e4 = '0;
    for (int l = 0; l < LANES; l++) begin
      int k = g * LANES + l;
      int n = 0;
      int v8, v4;
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          if (m_img[r+kr][c+kc] != m_ker[k][kr*K+kc]) n++;
      if (m_mode) n = KK - n;
      v8 = (n > 255) ? 255 : n;
      v4 = (n > 15) ? 15 : n;
      e8 = (e8 << BW) | 128'(v8);
      e4 = (e4 << BW2) | 128'(v4);
    end
  endtask

  task automatic load_inputs();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        i_image[r*IMG_W+c] = m_img[r][c];
    for (int k = 0; k < N_KER; k++)
      for (int i = 0; i < KK; i++)
        i_kernels[k*KK+i] = m_ker[k][i];
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < IMG_H*IMG_W; i++)
      i_image[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < N_KER*KK; i++)
      i_kernels[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic fill(input int img_v, input int ker_v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        m_img[r][c] = (img_v < 0) ? 1'($urandom_range(0, 1))
                                  : 1'(img_v);
    for (int k = 0; k < N_KER; k++)
      for (int i = 0; i < KK; i++)
        m_ker[k][i] = (ker_v < 0) ? 1'($urandom_range(0, 1))
                                  : 1'(ker_v);
  endtask

  task automatic run_frame(input bit xm, input int rdy_pct,
                           input int stall_beat, input int abort_at,
                           input bit hold_start);
    int e = 0;
    int n = 0;
    int first_n = -1;
    int last_n = -1;
    int stall_left = 3;
    int budget = TOTAL * 4 + 200;
    bit stalled = 0;
    bit finished = 0;
    logic [127:0] h8, h4, hc, e8, e4;
    m_mode = xm;
    load_inputs();
    @(negedge clk);
    i_start = 1'b1;
    i_xnor_mode = xm;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    check("busy_after_start", 128'(busy), 1);
    check("no_valid_at_t1", 128'(valid), 0);
    if (!hold_start) i_start = 1'b0;
    scramble_inputs();
    i_xnor_mode = ~xm;
    while (!finished && n < budget) begin
      if (done) begin
        check("done_timing", n, last_n + 1);
        check("beat_count", e, TOTAL);
        check("valid_at_done", 128'(valid), 0);
        check("busy_at_done", 128'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", 128'(done), 0);
        check("idle_after_done", 128'(busy), 0);
        i_start = 1'b0;
        finished = 1;
      end else begin
        if (valid) begin
          if (first_n < 0) begin
            first_n = n;
            check("first_valid_latency", n, 2);
          end
          if (stalled) begin
            check("stall_hold_data", 128'(data), h8);
            check("stall_hold_sat", 128'(data2), h4);
            check("stall_hold_pos", 128'({grp, row, col}), hc);
          end
          if (e == stall_beat && stall_left > 0) begin
            i_ready = 1'b0;
            stall_left--;
          end else begin
            i_ready = ($urandom_range(0, 99) < rdy_pct);
          end
          if (i_ready) begin
            int g = e / (OUT_H * OUT_W);
            int r = (e / OUT_W) % OUT_H;
            int c = e % OUT_W;
            ref_beat(g, r, c, e8, e4);
            check("beat_pos", 128'({grp, row, col}),
                  128'((g << (RW + CW)) | (r << CW) | c));
            check("beat_data", 128'(data), e8);
            check("beat_data_sat", 128'(data2), e4);
            e++;
            last_n = n;
            stalled = 0;
            if (e == abort_at) begin
              rst = 1'b1;
              #1;
              check("abort_valid", 128'(valid), 0);
              check("abort_busy", 128'(busy), 0);
              @(negedge clk);
              check("abort_no_done", 128'(done), 0);
              rst = 1'b0;
              i_start = 1'b0;
              return;
            end
          end else begin
            stalled = 1;
            h8 = 128'(data);
            h4 = 128'(data2);
            hc = 128'({grp, row, col});
          end
        end else begin
          stalled = 0;
          i_ready = 1'b1;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!finished) check("frame_timeout", 0, 1);
    i_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_xnor_mode = 1'b0;
    i_image = '0;
    i_kernels = '0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 128'(valid), 0);
    check("rst_done", 128'(done), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_data", 128'(data), 0);
    check("rst_pos", 128'({grp, row, col}), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(0, 0);
    run_frame(1'b0, 100, -1, -1, 1'b0);

    fill(0, 0);
    run_frame(1'b1, 100, -1, -1, 1'b0);

    fill(1, 0);
    for (int i = 0; i < KK; i++) m_ker[0][i] = 1'b1;
    run_frame(1'b0, 100, -1, -1, 1'b0);

    fill(0, 0);
    m_img[0][0] = 1'b1;
    run_frame(1'b0, 100, 5, -1, 1'b0);

    fill(-1, -1);
    run_frame(1'b0, 70, -1, 100, 1'b0);
    @(negedge clk);

    fill(-1, -1);
    run_frame(1'b1, 60, 5, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_conv_stream.md
Name: bnn_conv_stream

Overview:
- Sequential, parametrised binary convolution engine; successor to the fully combinational first conv layer.
- Latches one binary image and a bank of binary kernels on start.
- Walks every kernel group and output position, producing LANES popcount results per beat on a valid/ready stream.
- Adds selectable XOR/XNOR counting, backpressure, start/done control and output saturation.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, square kernel side
- N_KER, 90, kernel count; must be a multiple of LANES
- LANES, 10, kernels evaluated in parallel per beat
- bW, 8, result width per lane

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- i_start  input  1  start pulse; sampled only in IDLE
- i_xnor_mode  input  1  0 = count mismatches (XOR), 1 = count matches (XNOR); latched on start
- i_image  input  IMG_H*IMG_W  binary image, [0:N-1] ordering, bit row*IMG_W+col
- i_kernels  input  N_KER*K*K  kernel k at bits [k*K*K : (k+1)*K*K-1], inner index kr*K+kc
- o_busy  output  1  high from accepted start until done pulse
- o_done  output  1  one-cycle pulse after last beat accepted
- o_valid  output  1  o_data/o_grp/o_row/o_col valid
- i_ready  input  1  consumer accepts beat when o_valid & i_ready
- o_data  output  LANES*bW  lane l at bits [l*bW:(l+1)*bW-1], result for kernel grp*LANES+l
- o_grp  output  clog2(N_KER/LANES)  kernel group of current beat
- o_row  output  clog2(OUT_H)  output row
- o_col  output  clog2(OUT_W)  output column

Behaviour:
- Definitions: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1, NG = N_KER/LANES, total beats = NG*OUT_H*OUT_W (5184 at defaults).
- Reset: state IDLE; o_busy, o_done, o_valid = 0; o_data, o_grp, o_row, o_col = 0; image, kernel and mode registers cleared. Reset mid-run abandons the frame with no o_done; resumes cleanly next cycle.
- FSM IDLE -> RUN:
  - On i_start in IDLE: latch image, kernels and mode; clear counters; o_busy = 1 next cycle.
  - i_start while not IDLE is ignored.
  - Latched data is immune to input changes during RUN.
- FSM RUN:
  - One registered pipeline stage.
  - Output register loads the next beat when (!o_valid | i_ready) and beats remain.
  - First o_valid is asserted the second cycle after the start edge (start edge T, counters valid T+1, o_valid at T+2).
  - One beat per cycle under continuous i_ready.
- Iteration order: col fastest, then row, then grp (grp outermost).
- Lane value: window pixel (row+kr, col+kc) compared with kernel bit kr*K+kc, counted over K*K positions.
  - XOR mode: number of unequal positions.
  - XNOR mode: K*K minus that count.
- Width rule: result saturates at 2^bW-1 when K*K exceeds it; otherwise exact, zero-extended.
- Stall: while o_valid & !i_ready, o_data/o_grp/o_row/o_col hold stable; no beat is dropped or duplicated.
- FSM RUN -> DONE -> IDLE:
  - After the final beat is accepted: o_valid = 0 and o_done = 1 for exactly one cycle (DONE state); o_busy drops in the same cycle.
  - Then IDLE.
  - i_start in the DONE cycle is ignored.
- Simultaneous events: last-beat acceptance plus new i_start → start ignored. rst dominates all.

Test Plan:
- Image all 0, kernels all 0, XOR, i_ready=1 → 5184 beats, every lane 0, last beat grp=8 row=23 col=23, o_done pulse one cycle after its acceptance.
- Same stimulus, XNOR → every lane = 25; first o_valid exactly 2 cycles after start edge.
- Image all 1, kernel 0 all 1, others 0, XOR → in grp 0 lane0 = 0 and lanes1-9 = 25; in grps 1-8 all lanes = 25.
- Single pixel (0,0)=1, kernels 0, XOR → beats with row=0,col=0 show 1 on all lanes; all other beats 0.
- i_ready low 3 cycles while beat 5 is presented → o_data/o_col frozen at col=5; next accepted beat col=6; total beat count still 5184.
- rst pulse at beat 100, then new start → no o_done, o_valid 0 during reset; new frame starts at grp 0, row 0, col 0.
- bW=4, XNOR, all-match → lanes = 15 (saturated).
- i_start held during RUN → no restart; counters continue.
